// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Each access takes three cycles (IDLE arbitration, ACCESS, RESP), so the RAM
// serves at most one request every three cycles. Out-of-range word addresses
// never reach the RAM and raise a one-cycle addr_err alongside the ready strobe.
module ram_port_arbiter #(
    parameter int RAM_AW    = 10,
    parameter int RAM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    // requester 0 (CPU)
    input  logic              m0_valid,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_ready,
    output logic [31:0]       m0_rdata,
    // requester 1 (loader / debug)
    input  logic              m1_valid,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_ready,
    output logic [31:0]       m1_rdata,
    // RAM side
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    // status
    output logic              grant,
    output logic              addr_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Comparing the full byte address against the byte limit is the same test
    // as addr[31:2] < RAM_WORDS, and the 33-bit width avoids overflow.
    localparam logic [32:0] BYTE_LIMIT = 33'(RAM_WORDS) << 2;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              in_range_q, in_range_d;

    logic              pick;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_wstrb;
    logic [31:0]       resp_data;

    // Winner selection: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        pick      = (m0_valid && m1_valid) ? ~last_grant_q : m1_valid;
        sel_addr  = pick ? m1_addr  : m0_addr;
        sel_wdata = pick ? m1_wdata : m0_wdata;
        sel_wstrb = pick ? m1_wstrb : m0_wstrb;
    end

    // Next-state logic; request fields are latched only when leaving IDLE.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        in_range_d   = in_range_q;
        case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    addr_d       = sel_addr[RAM_AW+1:2];
                    wdata_d      = sel_wdata;
                    wstrb_d      = sel_wstrb;
                    in_range_d   = ({1'b0, sel_addr} < BYTE_LIMIT);
                    state_d      = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and request latches; last_grant resets to 1 so m0 wins the first tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            in_range_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            in_range_q   <= in_range_d;
        end
    end

    // Output decode: RAM strobes in ACCESS, ready/rdata/addr_err in RESP.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;
        m0_rdata  = 32'h0;
        m1_rdata  = 32'h0;
        addr_err  = 1'b0;
        grant     = grant_q;
        resp_data = (in_range_q && (wstrb_q == 4'b0000)) ? ram_rdata : 32'h0;
        if ((state_q == ACCESS) && in_range_q) begin
            ram_en = 1'b1;
            ram_we = wstrb_q;
        end
        if (state_q == RESP) begin
            addr_err = ~in_range_q;
            if (grant_q) begin
                m1_ready = 1'b1;
                m1_rdata = resp_data;
            end else begin
                m0_ready = 1'b1;
                m0_rdata = resp_data;
            end
        end
    end

endmodule
